spi_read_master: RTL

//   SPI mode-0 read master that feeds the serial-in shift_register stage. For each request it

---
 rtl/spi_read_master_if.sv | 30 +++
 rtl/spi_read_master.sv | 136 +++++++++++++
 2 files changed

// File: rtl/spi_read_master_if.sv
// Bundle of the request, SPI pin and shift_register feed signals of spi_read_master.
// Handshake: start is a level request. It is taken only when the master is idle and not in its
// done cycle, and the command word is captured on that same clock edge. busy then stays high
// until the done pulse. The master does not queue requests.
interface spi_read_master_if #(
  parameter int CMD_BITS = 16
);
  logic                start;
  logic [CMD_BITS-1:0] cmd_word;
  logic                busy;
  logic                done;
  logic                sclk;
  logic                cs_n;
  logic                mosi;
  logic                miso;
  logic                sr_data;
  logic                sr_enable;
  logic                sr_direction;
  logic [1:0]          state_dbg;

  modport master (
    input  start, cmd_word, miso,
    output busy, done, sclk, cs_n, mosi, sr_data, sr_enable, sr_direction, state_dbg
  );

  modport slave (
    output start, cmd_word, miso,
    input  busy, done, sclk, cs_n, mosi, sr_data, sr_enable, sr_direction, state_dbg
  );
endinterface

// File: rtl/spi_read_master.sv
// SPI mode-0 read master. It sends a CMD_BITS command MSB first, then samples DATA_BITS MISO
// bits. Each sampled bit goes to a downstream shift_register as a one-cycle data/enable pair.
module spi_read_master #(
  parameter int CLK_DIV   = 4,
  parameter int CMD_BITS  = 16,
  parameter int DATA_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  spi_read_master_if.master bus
);

  localparam int N  = CMD_BITS + DATA_BITS;
  localparam int BW = $clog2(N);
  localparam int PW = $clog2(CLK_DIV);

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [BW-1:0] BIT_CMD  = BW'(CMD_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t              state;
  logic [PW-1:0]       phase;
  logic [BW-1:0]       bit_idx;
  logic [CMD_BITS-1:0] cmd_sr;

  logic busy_q;
  logic done_q;
  logic sclk_q;
  logic cs_n_q;
  logic mosi_q;
  logic sr_data_q;
  logic sr_enable_q;

  // Transfer sequencer. All pin and feed outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      bit_idx     <= '0;
      cmd_sr      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      sr_data_q   <= 1'b0;
      sr_enable_q <= 1'b0;
    end else begin
      // done and sr_enable are single-cycle pulses.
      done_q      <= 1'b0;
      sr_enable_q <= 1'b0;
      case (state)
        IDLE: begin
          // Ignore a request during the done cycle, so that a held start restarts after one
          // idle cycle.
          if (bus.start && !done_q) begin
            cmd_sr  <= bus.cmd_word;
            mosi_q  <= bus.cmd_word[CMD_BITS-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            phase   <= '0;
            state   <= LEAD;
          end
        end
        LEAD: begin
          // Give the slave one half-period of select setup before the first rising edge.
          if (phase == PH_LAST) begin
            phase   <= '0;
            bit_idx <= '0;
            sclk_q  <= 1'b1;
            state   <= SHIFT;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        SHIFT: begin
          // Sample MISO in the first high cycle of a data-phase bit and hand it downstream.
          if (sclk_q && (phase == '0) && (bit_idx >= BIT_CMD)) begin
            sr_data_q   <= bus.miso;
            sr_enable_q <= 1'b1;
          end
          if (phase == PH_LAST) begin
            phase <= '0;
            if (sclk_q) begin
              // On a falling edge, present the next command bit. Zeros shifted in drive MOSI
              // low for the data phase.
              sclk_q <= 1'b0;
              cmd_sr <= {cmd_sr[CMD_BITS-2:0], 1'b0};
              mosi_q <= cmd_sr[CMD_BITS-2];
              if (bit_idx == BIT_LAST) begin
                state <= TRAIL;
              end
            end else begin
              sclk_q  <= 1'b1;
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        TRAIL: begin
          // Hold select for one half-period after the last falling edge, then release it.
          if (phase == PH_LAST) begin
            phase  <= '0;
            cs_n_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            mosi_q <= 1'b0;
            state  <= IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sclk         = sclk_q;
  assign bus.cs_n         = cs_n_q;
  assign bus.mosi         = mosi_q;
  assign bus.sr_data      = sr_data_q;
  assign bus.sr_enable    = sr_enable_q;
  assign bus.sr_direction = 1'b0;
  assign bus.state_dbg    = state;

endmodule
